// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_pkg
// Description : Control-word bit map, fetch words, enums and microcode lookup
//               for the microcoded control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package control_pkg;

    localparam int c_bit_hlt = 15;
    localparam int c_bit_mi  = 14;
    localparam int c_bit_ri  = 13;
    localparam int c_bit_ro  = 12;
    localparam int c_bit_io  = 11;
    localparam int c_bit_ii  = 10;
    localparam int c_bit_ai  = 9;
    localparam int c_bit_ao  = 8;
    localparam int c_bit_eo  = 7;
    localparam int c_bit_su  = 6;
    localparam int c_bit_bi  = 5;
    localparam int c_bit_oi  = 4;
    localparam int c_bit_ce  = 3;
    localparam int c_bit_co  = 2;
    localparam int c_bit_j   = 1;
    localparam int c_bit_fi  = 0;

    localparam logic [15:0] c_m_hlt = 16'(1) << c_bit_hlt;
    localparam logic [15:0] c_m_mi  = 16'(1) << c_bit_mi;
    localparam logic [15:0] c_m_ri  = 16'(1) << c_bit_ri;
    localparam logic [15:0] c_m_ro  = 16'(1) << c_bit_ro;
    localparam logic [15:0] c_m_io  = 16'(1) << c_bit_io;
    localparam logic [15:0] c_m_ii  = 16'(1) << c_bit_ii;
    localparam logic [15:0] c_m_ai  = 16'(1) << c_bit_ai;
    localparam logic [15:0] c_m_ao  = 16'(1) << c_bit_ao;
    localparam logic [15:0] c_m_eo  = 16'(1) << c_bit_eo;
    localparam logic [15:0] c_m_su  = 16'(1) << c_bit_su;
    localparam logic [15:0] c_m_bi  = 16'(1) << c_bit_bi;
    localparam logic [15:0] c_m_oi  = 16'(1) << c_bit_oi;
    localparam logic [15:0] c_m_ce  = 16'(1) << c_bit_ce;
    localparam logic [15:0] c_m_co  = 16'(1) << c_bit_co;
    localparam logic [15:0] c_m_j   = 16'(1) << c_bit_j;
    localparam logic [15:0] c_m_fi  = 16'(1) << c_bit_fi;

    localparam logic [15:0] c_fetch_t0 = c_m_co | c_m_mi;
    localparam logic [15:0] c_fetch_t1 = c_m_ro | c_m_ii | c_m_ce;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDA = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_STA = 4'd4,
        OP_LDI = 4'd5,
        OP_JMP = 4'd6,
        OP_JC  = 4'd7,
        OP_JZ  = 4'd8,
        OP_OUT = 4'd14,
        OP_HLT = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Returns {ctrl[15:0], last}; steps past the end of an entry read as a final NOP.
    function automatic logic [16:0] ucode_lookup(input logic [31:0] opcode,
                                                 input logic [31:0] step,
                                                 input logic        flag_c,
                                                 input logic        flag_z);
        logic [15:0] w_word;
        logic        w_last;
        logic [31:0] w_ex;
        opcode_e     w_op;
        w_word = '0;
        w_last = 1'b1;
        w_ex   = step - 32'd2;
        w_op   = OP_NOP;
        if (opcode < 32'd16) begin
            w_op = opcode_e'(opcode[3:0]);
        end
        if (step == 32'd0) begin
            w_word = c_fetch_t0;
            w_last = 1'b0;
        end else if (step == 32'd1) begin
            w_word = c_fetch_t1;
            w_last = 1'b0;
        end else begin
            case (w_op)
                OP_LDA, OP_STA: begin
                    if (w_ex == 32'd0) begin
                        w_word = c_m_io | c_m_mi;
                        w_last = 1'b0;
                    end else if (w_ex == 32'd1) begin
                        w_word = (w_op == OP_LDA) ? (c_m_ro | c_m_ai) : (c_m_ao | c_m_ri);
                    end
                end
                OP_ADD, OP_SUB: begin
                    if (w_ex == 32'd0) begin
                        w_word = c_m_io | c_m_mi;
                        w_last = 1'b0;
                    end else if (w_ex == 32'd1) begin
                        w_word = c_m_ro | c_m_bi;
                        w_last = 1'b0;
                    end else if (w_ex == 32'd2) begin
                        w_word = c_m_eo | c_m_ai | c_m_fi | ((w_op == OP_SUB) ? c_m_su : 16'h0000);
                    end
                end
                OP_LDI: if (w_ex == 32'd0) w_word = c_m_io | c_m_ai;
                OP_JMP: if (w_ex == 32'd0) w_word = c_m_io | c_m_j;
                OP_JC:  if (w_ex == 32'd0 && flag_c) w_word = c_m_io | c_m_j;
                OP_JZ:  if (w_ex == 32'd0 && flag_z) w_word = c_m_io | c_m_j;
                OP_OUT: if (w_ex == 32'd0) w_word = c_m_ao | c_m_oi;
                OP_HLT: if (w_ex == 32'd0) w_word = c_m_hlt;
                default: w_word = '0;
            endcase
        end
        return {w_word, w_last};
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Microcoded control sequencer issuing one 16-bit control word
//               per T-state, with memory stalls, halt and run/idle gating.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import control_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int STEPS       = 5,
    parameter int MEM_WAIT_EN = 1,
    parameter int RETIRE_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic [OPCODE_W-1:0]        opcode,
    input  logic                       flag_c,
    input  logic                       flag_z,
    input  logic                       mem_ready,
    output logic [15:0]                ctrl,
    output logic [$clog2(STEPS)-1:0]   step,
    output logic                       halted,
    output logic                       retire,
    output logic [RETIRE_W-1:0]        retired
);

    localparam int c_step_w = $clog2(STEPS);
    localparam logic [c_step_w-1:0] c_max_step = c_step_w'(STEPS - 1);

    state_e                r_state;
    logic [c_step_w-1:0]   r_step;
    logic                  r_halted;
    logic                  r_retire;
    logic [RETIRE_W-1:0]   r_retired;

    logic [16:0]           w_ucode;
    logic [15:0]           w_word;
    logic                  w_stall;
    logic                  w_done;

    always_comb begin
        w_ucode = ucode_lookup(32'(opcode), 32'(r_step), flag_c, flag_z);
        w_word  = (r_state == ST_RUN) ? w_ucode[16:1] : 16'h0000;
        w_stall = (MEM_WAIT_EN != 0) && (w_word[c_bit_ro] || w_word[c_bit_ri]) && !mem_ready;
        w_done  = w_ucode[0] || (r_step == c_max_step);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_step    <= '0;
            r_halted  <= 1'b0;
            r_retire  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state <= ST_RUN;
                        r_step  <= '0;
                    end
                end
                ST_RUN: begin
                    if (!w_stall) begin
                        if (w_done) begin
                            r_step    <= '0;
                            r_retire  <= 1'b1;
                            r_retired <= r_retired + RETIRE_W'(1);
                            // Halt wins over run so a halted program stays parked.
                            if (w_word[c_bit_hlt]) begin
                                r_state  <= ST_HALT;
                                r_halted <= 1'b1;
                            end else if (!run) begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_step <= r_step + c_step_w'(1);
                        end
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ctrl    = w_word;
    assign step    = r_step;
    assign halted  = r_halted;
    assign retire  = r_retire;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed self-checking bench for control_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, run_nw, flag_c, flag_z, mem_ready;
    logic [3:0]  opcode;
    logic [15:0] ctrl, ctrl_nw;
    logic [2:0]  step, step_nw;
    logic        halted, halted_nw, retire, retire_nw;
    logic [7:0]  retired, retired_nw;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    control_sequencer #(.OPCODE_W(4), .STEPS(5), .MEM_WAIT_EN(1), .RETIRE_W(8)) u_dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .mem_ready(mem_ready), .ctrl(ctrl), .step(step), .halted(halted),
        .retire(retire), .retired(retired)
    );

    control_sequencer #(.OPCODE_W(4), .STEPS(5), .MEM_WAIT_EN(0), .RETIRE_W(8)) u_nw (
        .clk(clk), .rst(rst), .run(run_nw), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .mem_ready(mem_ready), .ctrl(ctrl_nw), .step(step_nw), .halted(halted_nw),
        .retire(retire_nw), .retired(retired_nw)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic exp_main(input string tag, input logic [15:0] c, input int s,
                            input logic r, input int n, input logic h);
        check({tag, ".ctrl"},    32'(ctrl),    32'(c));
        check({tag, ".step"},    32'(step),    32'(s));
        check({tag, ".retire"},  32'(retire),  32'(r));
        check({tag, ".retired"}, 32'(retired), 32'(n));
        check({tag, ".halted"},  32'(halted),  32'(h));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; run_nw = 1'b0; opcode = 4'd5;
        flag_c = 1'b0; flag_z = 1'b0; mem_ready = 1'b1;
        cyc; cyc;
        exp_main("reset", 16'h0000, 0, 0, 0, 0);
        check("reset_nw.ctrl", 32'(ctrl_nw), 32'h0);
        rst = 1'b0;
        cyc;
        exp_main("idle", 16'h0000, 0, 0, 0, 0);

        // LDI
        run = 1'b1;
        cyc; exp_main("ldi_t0", 16'h4004, 0, 0, 0, 0);
        cyc; exp_main("ldi_t1", 16'h1408, 1, 0, 0, 0);
        cyc; exp_main("ldi_t2", 16'h0A00, 2, 0, 0, 0);
        cyc; exp_main("ldi_done", 16'h4004, 0, 1, 1, 0);

        // ADD, full length
        opcode = 4'd2;
        cyc; exp_main("add_t1", 16'h1408, 1, 0, 1, 0);
        cyc; exp_main("add_t2", 16'h4800, 2, 0, 1, 0);
        cyc; exp_main("add_t3", 16'h1020, 3, 0, 1, 0);
        cyc; exp_main("add_t4", 16'h0281, 4, 0, 1, 0);
        cyc; exp_main("add_done", 16'h4004, 0, 1, 2, 0);

        // ADD with run dropped at T1
        cyc; exp_main("drop_t1", 16'h1408, 1, 0, 2, 0);
        run = 1'b0;
        cyc; exp_main("drop_t2", 16'h4800, 2, 0, 2, 0);
        cyc; exp_main("drop_t3", 16'h1020, 3, 0, 2, 0);
        cyc; exp_main("drop_t4", 16'h0281, 4, 0, 2, 0);
        cyc; exp_main("drop_done", 16'h0000, 0, 1, 3, 0);
        cyc; exp_main("drop_idle", 16'h0000, 0, 0, 3, 0);

        // LDA with a 3-cycle memory stall at T3
        opcode = 4'd1; run = 1'b1;
        cyc; exp_main("lda_t0", 16'h4004, 0, 0, 3, 0);
        cyc; exp_main("lda_t1", 16'h1408, 1, 0, 3, 0);
        cyc; exp_main("lda_t2", 16'h4800, 2, 0, 3, 0);
        cyc; exp_main("lda_t3", 16'h1200, 3, 0, 3, 0);
        mem_ready = 1'b0; run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc; exp_main("lda_stall", 16'h1200, 3, 0, 3, 0);
        end
        mem_ready = 1'b1;
        cyc; exp_main("lda_done", 16'h0000, 0, 1, 4, 0);

        // Same LDA without memory waits: mem_ready low is ignored
        mem_ready = 1'b0; run_nw = 1'b1;
        cyc; check("nw_t0.ctrl", 32'(ctrl_nw), 32'h4004);
        cyc; check("nw_t1.ctrl", 32'(ctrl_nw), 32'h1408);
        check("nw_t1.step", 32'(step_nw), 32'd1);
        run_nw = 1'b0;
        cyc; check("nw_t2.ctrl", 32'(ctrl_nw), 32'h4800);
        cyc; check("nw_t3.ctrl", 32'(ctrl_nw), 32'h1200);
        cyc; check("nw_done.retire", 32'(retire_nw), 32'd1);
        check("nw_done.retired", 32'(retired_nw), 32'd1);
        check("nw_done.step", 32'(step_nw), 32'd0);
        check("nw_done.halted", 32'(halted_nw), 32'd0);
        exp_main("idle_hold", 16'h0000, 0, 0, 4, 0);
        mem_ready = 1'b1;

        // JC taken, flag dropped live, then not taken; JZ taken
        opcode = 4'd7; flag_c = 1'b1; run = 1'b1;
        cyc; cyc;
        cyc; exp_main("jc1_t2", 16'h0802, 2, 0, 4, 0);
        flag_c = 1'b0;
        #1 check("jc_live.ctrl", 32'(ctrl), 32'h0000);
        cyc; exp_main("jc1_done", 16'h4004, 0, 1, 5, 0);
        cyc;
        cyc; exp_main("jc0_t2", 16'h0000, 2, 0, 5, 0);
        cyc; exp_main("jc0_done", 16'h4004, 0, 1, 6, 0);
        opcode = 4'd8; flag_z = 1'b1;
        cyc;
        cyc; exp_main("jz_t2", 16'h0802, 2, 0, 6, 0);
        cyc; exp_main("jz_done", 16'h4004, 0, 1, 7, 0);

        // HLT
        opcode = 4'd15;
        cyc; exp_main("hlt_t1", 16'h1408, 1, 0, 7, 0);
        cyc; exp_main("hlt_t2", 16'h8000, 2, 0, 7, 0);
        cyc; exp_main("hlt_done", 16'h0000, 0, 1, 8, 1);
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            cyc; exp_main("halt_sticky", 16'h0000, 0, 0, 8, 1);
        end
        run = 1'b0;
        #3 rst = 1'b1;
        #1 exp_main("halt_rst", 16'h0000, 0, 0, 0, 0);
        cyc;
        rst = 1'b0;

        // 256 NOPs: retired wraps
        opcode = 4'd0; run = 1'b1;
        cyc; exp_main("nop_t0", 16'h4004, 0, 0, 0, 0);
        repeat (3 * 255) cyc;
        exp_main("nop_255", 16'h4004, 0, 1, 255, 0);
        repeat (3) cyc;
        exp_main("nop_wrap", 16'h4004, 0, 1, 0, 0);
        repeat (3) cyc;
        exp_main("nop_one", 16'h4004, 0, 1, 1, 0);

        // Asynchronous reset in the middle of a T3 stall
        opcode = 4'd2;
        cyc; cyc;
        cyc; exp_main("rst_t3", 16'h1020, 3, 0, 1, 0);
        mem_ready = 1'b0;
        cyc; exp_main("rst_stall", 16'h1020, 3, 0, 1, 0);
        #3 rst = 1'b1;
        #1 exp_main("mid_rst", 16'h0000, 0, 0, 0, 0);
        cyc; exp_main("rst_hold", 16'h0000, 0, 0, 0, 0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
